// File: rtl/tsr_pkg.sv
// Shared constants for the UART transmit shift register: state encoding and line levels.
// The PARITY state only exists in the FSM type when TSR_PARITY_EN is defined.
package tsr_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

`ifdef TSR_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_WAIT   = WAIT,
        S_START  = START,
        S_DATA   = DATA,
        S_PARITY = PARITY,
        S_STOP   = STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = IDLE,
        S_WAIT  = WAIT,
        S_START = START,
        S_DATA  = DATA,
        S_STOP  = STOP
    } state_t;
`endif

endpackage

// File: rtl/tsr_tick_edge.sv
// Rising-edge detector for the baud strobe; works for 1-clk pulses and slow square waves.
// Latency: tick_edge is combinational in bit_tick, valid in the cycle bit_tick first reads high.
module tsr_tick_edge (
    input  logic clk,
    input  logic reset,
    input  logic bit_tick,
    output logic tick_edge
);

    logic tick_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= bit_tick;
        end
    end

    assign tick_edge = bit_tick & ~tick_q;

endmodule

// File: rtl/tsr.sv
// UART TX shift register: start, DATA_SIZE bits LSB first, optional even parity (TSR_PARITY_EN), stop.
// Latency: request accepted 1 clk after tx_start in IDLE; start bit launches on the next tick edge.
// Backpressure: tx_busy high while a frame is pending or in flight; tx_start and d_i ignored then.
module tsr
    import tsr_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] d_i,
    input  logic                 bit_tick,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 data_out
);

    localparam int CW = $clog2(DATA_SIZE + 1);

    logic                 tick_edge;
    state_t               state_q, state_nxt;
    logic [DATA_SIZE-1:0] shift_q, shift_nxt;
    logic [CW-1:0]        cnt_q, cnt_nxt;
    logic                 line_nxt;
    logic                 busy_nxt;
`ifdef TSR_PARITY_EN
    logic                 parity_q, parity_nxt;
`endif

    tsr_tick_edge u_tick_edge (
        .clk       (clk),
        .reset     (reset),
        .bit_tick  (bit_tick),
        .tick_edge (tick_edge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            data_out <= LINE_IDLE;
            tx_busy  <= 1'b0;
`ifdef TSR_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_nxt;
            shift_q  <= shift_nxt;
            cnt_q    <= cnt_nxt;
            data_out <= line_nxt;
            tx_busy  <= busy_nxt;
`ifdef TSR_PARITY_EN
            parity_q <= parity_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state_q;
        shift_nxt  = shift_q;
        cnt_nxt    = cnt_q;
        line_nxt   = data_out;
        busy_nxt   = tx_busy;
`ifdef TSR_PARITY_EN
        parity_nxt = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                line_nxt = LINE_IDLE;
                busy_nxt = 1'b0;
                cnt_nxt  = '0;
                // Acceptance does not wait for a tick; WAIT aligns the start bit instead.
                if (tx_start) begin
                    shift_nxt  = d_i;
                    busy_nxt   = 1'b1;
                    state_nxt  = S_WAIT;
`ifdef TSR_PARITY_EN
                    parity_nxt = ^d_i;
`endif
                end
            end
            S_WAIT: begin
                if (tick_edge) begin
                    line_nxt  = START_BIT;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (tick_edge) begin
                    line_nxt  = shift_q[0];
                    shift_nxt = shift_q >> 1;
                    cnt_nxt   = CW'(1);
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (tick_edge) begin
                    if (cnt_q < CW'(DATA_SIZE)) begin
                        line_nxt  = shift_q[0];
                        shift_nxt = shift_q >> 1;
                        cnt_nxt   = cnt_q + CW'(1);
                    end else begin
`ifdef TSR_PARITY_EN
                        line_nxt  = parity_q;
                        state_nxt = S_PARITY;
`else
                        line_nxt  = STOP_BIT;
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef TSR_PARITY_EN
            S_PARITY: begin
                if (tick_edge) begin
                    line_nxt  = STOP_BIT;
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick_edge) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                line_nxt  = LINE_IDLE;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tsr.sv
// Bench for tsr: a 7-bit and an 8-bit instance share stimulus; a frame-level model predicts the line.
module tb_tsr;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       bit_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] d_i      = 8'h00;
    logic [1:0] busy;
    logic [1:0] line;
    int         tick_mode = 0;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef TSR_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int BASIC_EXP = PAR ? 'h2FA : 'h1FA;
    localparam int BASIC_LEN = PAR ? 10 : 9;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DS = 7 + g;
        tsr #(.DATA_SIZE(DS)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .d_i      (d_i[DS-1:0]),
            .bit_tick (bit_tick),
            .tx_start (tx_start),
            .tx_busy  (busy[g]),
            .data_out (line[g])
        );
    end

    // Baud source: 16 ns square wave first, later random single-clk-aligned levels.
    initial begin
        forever begin
            if (tick_mode == 0) begin
                #16;
                bit_tick = ~bit_tick;
            end else begin
                @(posedge clk);
                #3;
                bit_tick = ($urandom_range(0, 3) == 0);
            end
        end
    end

    bit          m_tq;
    bit          m_busy [2];
    bit          m_line [2];
    bit          m_emit [2];
    bit          m_frame[2][12];
    int          m_len  [2];
    int          m_pos  [2];
    logic [15:0] cap_val[2];
    int          cap_n  [2];
    logic [15:0] last_cap[2];
    int          last_n [2];
    int          frames_done[2];
    bit          prev_busy[2];
    int          low_run  = 0;
    int          last_gap = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // A frame is a list of line levels, one per tick edge after acceptance; busy drops one edge after the list runs out.
    task automatic model_step();
        bit edge_now;
        bit p;
        int ds;
        edge_now = bit_tick & ~m_tq;
        if (reset) begin
            m_tq = 1'b0;
            for (int g = 0; g < 2; g++) begin
                m_busy[g] = 1'b0;
                m_line[g] = 1'b1;
                m_emit[g] = 1'b0;
                m_pos[g]  = 0;
            end
        end else begin
            m_tq = bit_tick;
            for (int g = 0; g < 2; g++) begin
                ds = 7 + g;
                m_emit[g] = 1'b0;
                if (!m_busy[g]) begin
                    if (tx_start) begin
                        m_frame[g][0] = 1'b0;
                        p = 1'b0;
                        for (int i = 0; i < ds; i++) begin
                            m_frame[g][1+i] = d_i[i];
                            p = p ^ d_i[i];
                        end
                        m_len[g] = ds + 1;
                        if (PAR) begin
                            m_frame[g][m_len[g]] = p;
                            m_len[g]++;
                        end
                        m_frame[g][m_len[g]] = 1'b1;
                        m_len[g]++;
                        m_pos[g]   = 0;
                        m_busy[g]  = 1'b1;
                        cap_n[g]   = 0;
                        cap_val[g] = '0;
                    end
                end else if (edge_now) begin
                    if (m_pos[g] < m_len[g]) begin
                        m_line[g] = m_frame[g][m_pos[g]];
                        m_pos[g]++;
                        m_emit[g] = 1'b1;
                    end else begin
                        m_busy[g] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic compare_step();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("tx_busy[%0d]", g), int'(busy[g]), int'(m_busy[g]));
            check($sformatf("data_out[%0d]", g), int'(line[g]), int'(m_line[g]));
            if (m_emit[g] && cap_n[g] < 16) begin
                cap_val[g][cap_n[g]] = line[g];
                cap_n[g]++;
            end
            if (prev_busy[g] && !m_busy[g]) begin
                last_cap[g] = cap_val[g];
                last_n[g]   = cap_n[g];
                frames_done[g]++;
            end
            prev_busy[g] = m_busy[g];
        end
        if (!m_busy[0]) begin
            low_run++;
        end else begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_frame(input int g, input string name);
        int start;
        int k;
        start = frames_done[g];
        k = 0;
        while (frames_done[g] == start && k < 600) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (frames_done[g] == start) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((m_busy[0] || m_busy[1]) && k < 800) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (m_busy[0] || m_busy[1]) check({name, "_idle_timeout"}, 0, 1);
    endtask

    initial begin
        int k;
        for (int g = 0; g < 2; g++) begin
            m_busy[g] = 1'b0;
            m_line[g] = 1'b1;
            m_emit[g] = 1'b0;
            cap_n[g] = 0;
            cap_val[g] = '0;
            frames_done[g] = 0;
            prev_busy[g] = 1'b0;
            last_n[g] = 0;
            last_cap[g] = '0;
        end
        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                compare_step();
            end
        join_none

        // Reset, then 20 bit periods of idle line.
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(64);
        check("idle_busy", int'(busy), 0);
        check("idle_line", int'(line), 3);

        // Basic frame: 7'b1111101 -> 0,1,0,1,1,1,1,1,1.
        d_i = 8'h7D;
        tx_start = 1'b1;
        cycles(1);
        check("busy_rise", int'(busy[0]), 1);
        tx_start = 1'b0;
        wait_frame(0, "basic");
        check("basic_len", last_n[0], BASIC_LEN);
        check("basic_bits", int'(last_cap[0][9:0]), BASIC_EXP);
        wait_idle("basic");

        // Back-to-back frames with tx_start held.
        tx_start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_frame(0, "b2b");
            check("b2b_bits", int'(last_cap[0][9:0]), BASIC_EXP);
            if (f > 0) check("b2b_gap", last_gap, 1);
        end
        tx_start = 1'b0;
        wait_idle("b2b");

        // Data change mid-frame must not alter the frame.
        d_i = 8'hA5;
        tx_start = 1'b1;
        cycles(1);
        tx_start = 1'b0;
        cycles(8);
        d_i = 8'hFF;
        wait_frame(1, "a5");
        check("a5_bits", int'(last_cap[1][8:1]), 'hA5);
        wait_idle("a5");

        // Reset during data bit 3.
        d_i = 8'h3C;
        tx_start = 1'b1;
        cycles(1);
        tx_start = 1'b0;
        k = 0;
        while (cap_n[1] < 5 && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (cap_n[1] < 5) check("rst_wait_timeout", 0, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_line", int'(line), 3);
        d_i = 8'hA5;
        tx_start = 1'b1;
        cycles(1);
        tx_start = 1'b0;
        wait_frame(1, "post_rst");
        check("post_rst_bits", int'(last_cap[1][8:1]), 'hA5);
        check("post_rst_len", last_n[1], PAR ? 11 : 10);
        wait_idle("post_rst");

`ifdef TSR_PARITY_EN
        d_i = 8'h07;
        tx_start = 1'b1;
        cycles(1);
        tx_start = 1'b0;
        wait_frame(1, "par07");
        check("par07_bit", int'(last_cap[1][9]), 1);
        check("par07_len", last_n[1], 11);
        wait_idle("par07");
        d_i = 8'h03;
        tx_start = 1'b1;
        cycles(1);
        tx_start = 1'b0;
        wait_frame(1, "par03");
        check("par03_bit", int'(last_cap[1][9]), 0);
        wait_idle("par03");
`endif

        // Random pulse-mode ticks, random data/requests, rare resets.
        tick_mode = 1;
        repeat (3000) begin
            d_i      = 8'($urandom);
            tx_start = ($urandom_range(0, 2) != 0);
            reset    = ($urandom_range(0, 499) == 0);
            cycles(1);
        end
        reset = 1'b0;
        tx_start = 1'b0;
        wait_idle("random");
        cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
